pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if - bundle between the pipeline sequencer and the core.
//
// Signals:
//   stallreq_id_i / stallreq_ex_i : same-cycle stall requests from decode / execute
//   mc_start_i, mc_len_i          : multi-cycle op start and its total EX occupancy
//   flush_req_i, flush_pc_i       : flush request and redirect target
//   stall_o                       : per-stage stall vector {wb,mem,ex,id,if,pc}
//   flush_o, new_pc_o             : registered flush pulse and redirect PC
//   mc_busy_o, mc_done_o          : multi-cycle op in progress / committing
//   stall_cnt_o                   : saturating stalled-cycle count
//
// Modports: master = the core side driving requests, slave = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 6,
    parameter int PC_W   = 32,
    parameter int STAT_W = 32
);
    logic              stallreq_id_i;
    logic              stallreq_ex_i;
    logic              mc_start_i;
    logic [CNT_W-1:0]  mc_len_i;
    logic              flush_req_i;
    logic [PC_W-1:0]   flush_pc_i;
    logic [5:0]        stall_o;
    logic              flush_o;
    logic [PC_W-1:0]   new_pc_o;
    logic              mc_busy_o;
    logic              mc_done_o;
    logic [STAT_W-1:0] stall_cnt_o;

    modport master (
        output stallreq_id_i, stallreq_ex_i, mc_start_i, mc_len_i,
               flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_id_i, stallreq_ex_i, mc_start_i, mc_len_i,
               flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - central sequencer for the 5-stage pipeline.
//
// Merges decode/execute stall requests, times multi-cycle execute ops with a
// down-counter, sequences flushes with a redirect PC and keeps a saturating
// count of stalled cycles.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : pipe_ctrl_if.slave (requests in, stall/flush/status out)
//
// stall_o and mc_done_o are combinational from state, counter and inputs;
// flush_o, new_pc_o and mc_busy_o are decoded from registered state only.
module pipe_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PC_W   = 32,
    parameter int STAT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // pc, if, id, ex held for an execute-side stall; pc, if, id for load-use.
    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0] run_stall;
    logic [5:0] stall_v;
    logic       mc_done_v;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        stall_v   = '0;
        mc_done_v = 1'b0;

        if (bus.stallreq_ex_i) begin
            run_stall = STALL_EX;
        end else if (bus.stallreq_id_i) begin
            run_stall = STALL_ID;
        end else begin
            run_stall = '0;
        end

        if (bus.flush_req_i) begin
            // Flush wins over everything: abort any multi-cycle op and
            // (re)latch the redirect target.
            pc_d    = bus.flush_pc_i;
            cnt_d   = '0;
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mc_start_i && (bus.mc_len_i >= CNT_W'(2))) begin
                        stall_v = STALL_EX;
                        cnt_d   = bus.mc_len_i - CNT_W'(1);
                        state_d = ST_MC_BUSY;
                    end else begin
                        // Lengths 0 and 1 complete in the start cycle.
                        stall_v   = run_stall;
                        mc_done_v = bus.mc_start_i;
                    end
                end
                ST_MC_BUSY: begin
                    if (cnt_q > CNT_W'(1)) begin
                        stall_v = STALL_EX;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        // Final cycle: result commits and EX is free again,
                        // so ordinary stall requests apply.
                        mc_done_v = (cnt_q == CNT_W'(1));
                        stall_v   = run_stall;
                        cnt_d     = '0;
                        state_d   = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            endcase
        end

        if (rst) begin
            stall_v   = '0;
            mc_done_v = 1'b0;
        end

        if ((stall_v != 6'd0) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_o     = stall_v;
    assign bus.mc_done_o   = mc_done_v;
    assign bus.flush_o     = (state_q == ST_FLUSH);
    assign bus.mc_busy_o   = (state_q == ST_MC_BUSY);
    assign bus.new_pc_o    = pc_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int CNT_W  = 6;
    localparam int PC_W   = 32;
    localparam int STAT_W = 8;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(CNT_W), .PC_W(PC_W), .STAT_W(STAT_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              sid;
        logic              sex;
        logic              mcs;
        logic [CNT_W-1:0]  len;
        logic              frq;
        logic [PC_W-1:0]   fpc;
        logic [5:0]        e_stall;
        logic              e_done;
        logic              e_flush;
        logic [PC_W-1:0]   e_npc;
        logic              e_busy;
        logic [STAT_W-1:0] e_scnt;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    function automatic vec_t mk(
        input logic r, input logic sid, input logic sex, input logic mcs,
        input int len, input logic frq, input logic [31:0] fpc,
        input logic [5:0] st, input logic dn, input logic fl,
        input logic [31:0] npc, input logic bsy, input int scnt
    );
        vec_t v;
        v.rst = r; v.sid = sid; v.sex = sex; v.mcs = mcs;
        v.len = CNT_W'(len); v.frq = frq; v.fpc = fpc;
        v.e_stall = st; v.e_done = dn; v.e_flush = fl;
        v.e_npc = npc; v.e_busy = bsy; v.e_scnt = STAT_W'(scnt);
        return v;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL row%0d %s got=%h want=%h", row, name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.stallreq_id_i = v.sid;
        bus.stallreq_ex_i = v.sex;
        bus.mc_start_i    = v.mcs;
        bus.mc_len_i      = v.len;
        bus.flush_req_i   = v.frq;
        bus.flush_pc_i    = v.fpc;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // rst sid sex mcs len frq fpc | stall done flush npc busy scnt
        // Reset held with every request active
        vecs.push_back(mk(1,1,0,1,5,1,32'h55,  6'h00,0,0,32'h0,0,0));
        vecs.push_back(mk(1,1,0,1,5,1,32'h55,  6'h00,0,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0,0));
        // Load-use for one cycle
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,   6'h07,0,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0,1));
        // Multi-cycle op of length 5 (stall reqs / restart ignored while busy)
        vecs.push_back(mk(0,0,0,1,5,0,32'h0,   6'h0f,0,0,32'h0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,   6'h0f,0,0,32'h0,1,2));
        vecs.push_back(mk(0,0,0,1,2,0,32'h0,   6'h0f,0,0,32'h0,1,3));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h0f,0,0,32'h0,1,4));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,1,0,32'h0,1,5));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0,5));
        // Length-8 op aborted by a flush two cycles in
        vecs.push_back(mk(0,0,0,1,8,0,32'h0,   6'h0f,0,0,32'h0,0,5));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h0f,0,0,32'h0,1,6));
        vecs.push_back(mk(0,0,1,0,0,1,32'h40,  6'h00,0,0,32'h0,1,7));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,   6'h00,0,1,32'h40,0,7));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h40,0,7));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h40,0,7));
        // Short ops: length 1 with load-use, length 0 with ex stall
        vecs.push_back(mk(0,1,0,1,1,0,32'h0,   6'h07,1,0,32'h40,0,7));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h40,0,8));
        vecs.push_back(mk(0,0,1,1,0,0,32'h0,   6'h0f,1,0,32'h40,0,8));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h40,0,9));
        // Back-to-back flush
        vecs.push_back(mk(0,0,0,0,0,1,32'h100, 6'h00,0,0,32'h40,0,9));
        vecs.push_back(mk(0,0,0,0,0,1,32'h200, 6'h00,0,1,32'h100,0,9));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,1,32'h200,0,9));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,   6'h07,0,0,32'h200,0,9));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h200,0,10));
        // Flush and mc_start together: start dropped
        vecs.push_back(mk(0,0,0,1,4,1,32'h300, 6'h00,0,0,32'h200,0,10));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,1,32'h300,0,10));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h300,0,10));
        // Length 2 op: last busy cycle honours ex stall
        vecs.push_back(mk(0,0,0,1,2,0,32'h0,   6'h0f,0,0,32'h300,0,10));
        vecs.push_back(mk(0,0,1,0,0,0,32'h0,   6'h0f,1,0,32'h300,1,11));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h300,0,12));
        // Reset in the middle of an op
        vecs.push_back(mk(0,0,0,1,6,0,32'h0,   6'h0f,0,0,32'h300,0,12));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,   6'h00,0,0,32'h300,1,13));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,0,32'h0,0,0));

        drive(vecs[0]);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check("stall_o",     i, 32'(bus.stall_o),     32'(vecs[i].e_stall));
            check("mc_done_o",   i, 32'(bus.mc_done_o),   32'(vecs[i].e_done));
            check("flush_o",     i, 32'(bus.flush_o),     32'(vecs[i].e_flush));
            check("new_pc_o",    i, 32'(bus.new_pc_o),    32'(vecs[i].e_npc));
            check("mc_busy_o",   i, 32'(bus.mc_busy_o),   32'(vecs[i].e_busy));
            check("stall_cnt_o", i, 32'(bus.stall_cnt_o), 32'(vecs[i].e_scnt));
            $display("row %0d: rst=%0b sid=%0b sex=%0b mcs=%0b len=%0d frq=%0b -> stall=%h done=%0b flush=%0b pc=%h busy=%0b cnt=%0d",
                     i, vecs[i].rst, vecs[i].sid, vecs[i].sex, vecs[i].mcs,
                     vecs[i].len, vecs[i].frq, bus.stall_o, bus.mc_done_o,
                     bus.flush_o, bus.new_pc_o, bus.mc_busy_o, bus.stall_cnt_o);
            @(posedge clk);
        end

        // Continuous load-use stall from a cleared counter: count must stop
        // at all-ones instead of wrapping.
        for (int k = 0; k < 262; k++) begin
            #1;
            rst               = 1'b0;
            bus.stallreq_id_i = 1'b1;
            bus.stallreq_ex_i = 1'b0;
            bus.mc_start_i    = 1'b0;
            bus.mc_len_i      = '0;
            bus.flush_req_i   = 1'b0;
            bus.flush_pc_i    = '0;
            @(negedge clk);
            if (k < 4 || k > 252) begin
                check("sat_stall_o", 100 + k, 32'(bus.stall_o), 32'h07);
                check("sat_cnt", 100 + k, 32'(bus.stall_cnt_o),
                      (k > 255) ? 32'd255 : 32'(k));
                $display("sat cycle %0d: stall_cnt=%0d", k, bus.stall_cnt_o);
            end
            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
